// File: rtl/debug_pkg.sv
// debug_pkg: shared state encodings, framing defaults and source indices for the debug TX path
package debug_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_ID, S_LEN, S_PAYLOAD, S_CSUM, S_GUARD, S_DRAIN
  } state_t;
  localparam logic [7:0] SYNC_BYTE_D = 8'h7E;
  localparam logic [7:0] ID_BASE_D   = 8'h10;
  localparam int SRC_IMU    = 0;
  localparam int SRC_RC     = 1;
  localparam int SRC_MOTOR  = 2;
  localparam int SRC_STATUS = 3;
endpackage

// File: rtl/debug_tx_arbiter_if.sv
// debug_tx_arbiter_if: source request/payload bundle plus the uart_tx send/busy handshake
interface debug_tx_arbiter_if #(parameter int NUM_SRC = 4);
  logic [NUM_SRC-1:0]   req;
  logic [8*NUM_SRC-1:0] req_len;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_pop;
  logic [NUM_SRC-1:0]   grant;
  logic                 tx_send;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 pkt_done;
  modport master (output req, req_len, src_data, tx_busy,
                  input src_pop, grant, tx_send, tx_data, pkt_done);
  modport slave  (input req, req_len, src_data, tx_busy,
                  output src_pop, grant, tx_send, tx_data, pkt_done);
endinterface

// File: rtl/debug_tx_arbiter_rr_pick.sv
// rr_pick: first requester at or after the round-robin pointer, wrapping modulo N
module rr_pick import debug_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  // scan offsets from far to near so the nearest set bit after the pointer wins
  always_comb begin
    o_idx   = '0;
    o_valid = |i_req;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[IW'((int'(i_ptr) + i) % N)]) o_idx = IW'((int'(i_ptr) + i) % N);
    end
  end
endmodule

// File: rtl/debug_tx_arbiter.sv
// debug_tx_arbiter: round-robin packet framer sharing one uart_tx among telemetry sources
module debug_tx_arbiter import debug_pkg::*; #(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_D,
  parameter logic [7:0] ID_BASE   = ID_BASE_D
) (
  input logic                clock,
  input logic                reset_n,
  debug_tx_arbiter_if.slave  bus
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  state_t               r_state, w_state, r_field, w_field;
  logic [IW-1:0]        r_k, w_k, r_ptr, w_ptr, w_win;
  logic                 w_valid;
  logic [7:0]           r_rem, w_rem, r_csum, w_csum, r_data, w_data, w_len, w_src_byte;
  logic [NUM_SRC-1:0]   r_grant, w_grant, r_pop, w_pop;
  logic                 r_send, w_send, r_done, w_done;

  rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
    .i_req(bus.req), .i_ptr(r_ptr), .o_idx(w_win), .o_valid(w_valid)
  );

  assign w_len      = bus.req_len[{w_win, 3'b000} +: 8];
  assign w_src_byte = bus.src_data[{r_k, 3'b000} +: 8];
  assign bus.grant    = r_grant;
  assign bus.src_pop  = r_pop;
  assign bus.tx_send  = r_send;
  assign bus.tx_data  = r_data;
  assign bus.pkt_done = r_done;

  // next-state: arbitrate in IDLE, send one field when uart idle, guard a cycle, drain, advance
  always_comb begin
    w_state = r_state;
    w_field = r_field;
    w_k     = r_k;
    w_ptr   = r_ptr;
    w_rem   = r_rem;
    w_csum  = r_csum;
    w_data  = r_data;
    w_grant = r_grant;
    w_pop   = '0;
    w_send  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: if (w_valid) begin
        w_k     = w_win;
        w_grant = NUM_SRC'(1) << w_win;
        w_rem   = w_len;
        w_csum  = '0;
        w_state = S_SYNC;
      end
      S_SYNC, S_ID, S_LEN, S_PAYLOAD, S_CSUM: if (!bus.tx_busy) begin
        w_send  = 1'b1;
        w_field = r_state;
        w_state = S_GUARD;
        w_data  = r_state == S_SYNC    ? SYNC_BYTE :
                  r_state == S_ID      ? ID_BASE + 8'(r_k) :
                  r_state == S_LEN     ? r_rem :
                  r_state == S_PAYLOAD ? w_src_byte : r_csum;
        w_csum  = (r_state == S_SYNC || r_state == S_CSUM) ? r_csum : r_csum ^ w_data;
        if (r_state == S_PAYLOAD) begin
          w_pop = r_grant;
          w_rem = r_rem - 8'd1;
        end
      end
      S_GUARD: w_state = S_DRAIN;
      S_DRAIN: if (!bus.tx_busy) begin
        case (r_field)
          S_SYNC:            w_state = S_ID;
          S_ID:              w_state = S_LEN;
          S_LEN, S_PAYLOAD:  w_state = r_rem == 8'd0 ? S_CSUM : S_PAYLOAD;
          default: begin
            w_done  = 1'b1;
            w_grant = '0;
            w_ptr   = (int'(r_k) == NUM_SRC - 1) ? '0 : r_k + 1'b1;
            w_state = S_IDLE;
          end
        endcase
      end
      default: w_state = S_IDLE;
    endcase
  end

  // state, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_field <= S_IDLE;
      r_k     <= '0;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_csum  <= '0;
      r_data  <= '0;
      r_grant <= '0;
      r_pop   <= '0;
      r_send  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_field <= w_field;
      r_k     <= w_k;
      r_ptr   <= w_ptr;
      r_rem   <= w_rem;
      r_csum  <= w_csum;
      r_data  <= w_data;
      r_grant <= w_grant;
      r_pop   <= w_pop;
      r_send  <= w_send;
      r_done  <= w_done;
    end
  end
endmodule

// File: tb/tb_debug_tx_arbiter.sv
// tb_debug_tx_arbiter: randomized packet-level checks of the debug TX arbiter against a framing model
module tb_debug_tx_arbiter;
  localparam int NS = 4;
  logic clock = 0;
  logic reset_n = 0;
  always #5 clock = ~clock;

  debug_tx_arbiter_if #(.NUM_SRC(NS)) bus();
  debug_tx_arbiter #(.NUM_SRC(NS)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int errors = 0, checks = 0;
  logic [7:0] pay [NS][64];
  int didx [NS], mexp [NS], pops [NS];
  logic [7:0] cap [$], exp_q [$];
  int gq [$];
  int done_cnt = 0, two_hot = 0, viol = 0, unstable = 0, cnt = 0, busy_len = 3;
  logic pend = 0, model_busy = 0, force_busy = 0, mon_en = 0;
  logic [NS-1:0] prev_grant = '0;
  logic [7:0] last_tx = '0;

  assign bus.tx_busy = model_busy | force_busy;

  // uart busy model, source payload FIFOs and line monitor, all away from the active edge
  always @(negedge clock) begin
    if (bus.tx_send && bus.tx_busy) viol++;
    if (mon_en && !bus.tx_send && bus.tx_data !== last_tx) unstable++;
    if (bus.tx_send) begin
      cap.push_back(bus.tx_data);
      last_tx = bus.tx_data;
    end
    if (!$onehot0(bus.grant)) two_hot++;
    if (bus.grant != 0 && prev_grant == 0)
      for (int i = 0; i < NS; i++) if (bus.grant[i]) gq.push_back(i);
    prev_grant = bus.grant;
    if (bus.pkt_done) done_cnt++;
    for (int i = 0; i < NS; i++) if (bus.src_pop[i]) begin pops[i]++; didx[i]++; end
    for (int i = 0; i < NS; i++) bus.src_data[8*i +: 8] = pay[i][didx[i] % 64];
    if (!reset_n) begin cnt = 0; pend = 0; end
    else begin
      if (pend) cnt = busy_len; else if (cnt > 0) cnt--;
      pend = bus.tx_send;
    end
    model_busy = cnt > 0;
  end

  // expected wire image of one packet: SYNC, ID, LEN, payload, XOR of ID/LEN/payload
  task automatic exp_pkt(input int k, input int len);
    logic [7:0] cs, b;
    cs = 8'(8'h10 + k) ^ 8'(len);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'(8'h10 + k));
    exp_q.push_back(8'(len));
    for (int j = 0; j < len; j++) begin
      b = pay[k][mexp[k] % 64];
      mexp[k]++;
      exp_q.push_back(b);
      cs ^= b;
    end
    exp_q.push_back(cs);
  endtask

  function automatic bit same(input logic [7:0] a [$], input logic [7:0] b [$]);
    if (a.size() != b.size()) return 0;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 0;
    return 1;
  endfunction

  function automatic string qs(input logic [7:0] q [$]);
    string s = "";
    for (int i = 0; i < q.size() && i < 30; i++) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic wait_grant(output bit ok);
    ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clock);
      ok = bus.grant != 0;
    end
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge clock);
      ok = done_cnt >= n;
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    mon_en = 0;
    bus.req = '0;
    @(negedge clock);
    reset_n = 0;
    repeat (2) @(negedge clock);
    reset_n = 1;
    cap.delete(); gq.delete(); exp_q.delete();
    for (int i = 0; i < NS; i++) begin didx[i] = 0; mexp[i] = 0; pops[i] = 0; end
    done_cnt = 0; two_hot = 0; viol = 0; unstable = 0;
    last_tx = '0; force_busy = 0; busy_len = 3;
    @(negedge clock);
    mon_en = 1;
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 0;
    reset_n = 0;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.grant, bus.src_pop, bus.tx_send, bus.tx_data, bus.pkt_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b pop=%b send=%b data=%h done=%b, required all 0",
               bus.grant, bus.src_pop, bus.tx_send, bus.tx_data, bus.pkt_done);
    end
    reset_n = 1;
    repeat (6) @(negedge clock);
    mon_en = 1;
    checks++;
    if (bus.grant !== '0 || cap.size() != 0) begin
      errors++;
      $display("FAIL idle_quiet: grant=%b bytes=%0d, required grant=0 bytes=0", bus.grant, cap.size());
    end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    pay[1][0] = 8'h01; pay[1][1] = 8'h02; pay[1][2] = 8'h03;
    bus.req_len[8 +: 8] = 8'd3;
    bus.req = 4'b0010;
    @(negedge clock);
    checks++;
    if (bus.grant !== 4'b0010) begin
      errors++;
      $display("FAIL grant_latency: grant=%b one cycle after req, required 0010", bus.grant);
    end
    bus.req = '0;
    exp_pkt(1, 3);
    wait_done(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: pkt_done count=%0d, required 1", done_cnt); end
    checks++;
    if (!same(cap, exp_q)) begin
      errors++;
      $display("FAIL single_bytes: got %s required %s", qs(cap), qs(exp_q));
    end
    checks++;
    if (pops[1] != 3 || pops[0] + pops[2] + pops[3] != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL single_pops: pop1=%0d others=%0d done=%0d, required 3/0/1",
               pops[1], pops[0] + pops[2] + pops[3], done_cnt);
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    do_reset();
    bus.req_len[16 +: 8] = 8'd0;
    bus.req = 4'b0100;
    wait_grant(ok);
    bus.req = '0;
    exp_pkt(2, 0);
    wait_done(1, ok);
    checks++;
    if (!ok || !same(cap, exp_q)) begin
      errors++;
      $display("FAIL zero_len_bytes: got %s required %s", qs(cap), qs(exp_q));
    end
    checks++;
    if (pops[0] + pops[1] + pops[2] + pops[3] != 0 || bus.grant !== '0) begin
      errors++;
      $display("FAIL zero_len_pop: pops=%0d grant=%b, required 0 and 0000",
               pops[0] + pops[1] + pops[2] + pops[3], bus.grant);
    end
  endtask

  task automatic test_contention();
    bit ok;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NS; i++) begin
      bus.req_len[8*i +: 8] = 8'd1;
      for (int j = 0; j < 4; j++) pay[i][j] = 8'($urandom);
    end
    bus.req = 4'b1111;
    ok = 0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge clock);
      ok = gq.size() >= 5;
    end
    bus.req = '0;
    for (int i = 0; i < 5; i++) exp_pkt(order[i], 1);
    wait_done(5, ok);
    checks++;
    if (!ok || gq.size() != 5 || gq[0] != 0 || gq[1] != 1 || gq[2] != 2 || gq[3] != 3 || gq[4] != 0) begin
      errors++;
      $display("FAIL contention_order: %0d grants, first %0d %0d, required 0 1 2 3 0",
               gq.size(), gq.size() > 0 ? gq[0] : -1, gq.size() > 1 ? gq[1] : -1);
    end
    checks++;
    if (!same(cap, exp_q)) begin
      errors++;
      $display("FAIL contention_bytes: got %s required %s", qs(cap), qs(exp_q));
    end
    checks++;
    if (two_hot != 0) begin errors++; $display("FAIL grant_onehot: %0d bad cycles, required 0", two_hot); end
  endtask

  task automatic test_grant_lock();
    bit ok;
    do_reset();
    for (int j = 0; j < 8; j++) begin pay[0][j] = 8'($urandom); pay[3][j] = 8'($urandom); end
    bus.req_len[0 +: 8] = 8'd4;
    bus.req_len[24 +: 8] = 8'd2;
    bus.req = 4'b0001;
    ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clock);
      ok = cap.size() >= 2;
    end
    bus.req = 4'b1000;
    bus.req_len[0 +: 8] = 8'd9;
    ok = 0;
    for (int c = 0; c < 4000 && !ok; c++) begin
      @(negedge clock);
      ok = gq.size() >= 2;
    end
    bus.req = '0;
    exp_pkt(0, 4);
    exp_pkt(3, 2);
    wait_done(2, ok);
    checks++;
    if (gq.size() != 2 || gq[0] != 0 || gq[1] != 3) begin
      errors++;
      $display("FAIL lock_order: %0d grants, second=%0d, required 0 then 3",
               gq.size(), gq.size() > 1 ? gq[1] : -1);
    end
    checks++;
    if (!same(cap, exp_q)) begin
      errors++;
      $display("FAIL lock_bytes: got %s required %s", qs(cap), qs(exp_q));
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n0;
    do_reset();
    for (int j = 0; j < 16; j++) begin pay[1][j] = 8'($urandom); pay[3][j] = 8'($urandom); end
    bus.req_len[8 +: 8] = 8'd2;
    bus.req_len[24 +: 8] = 8'd10;
    bus.req = 4'b0010;
    wait_grant(ok);
    bus.req = '0;
    wait_done(1, ok);
    bus.req = 4'b1000;
    wait_grant(ok);
    bus.req = '0;
    ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clock);
      ok = pops[3] >= 2;
    end
    mon_en = 0;
    reset_n = 0;
    @(negedge clock);
    checks++;
    if ({bus.grant, bus.src_pop, bus.tx_send, bus.tx_data, bus.pkt_done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: grant=%b pop=%b send=%b data=%h done=%b, required all 0",
               bus.grant, bus.src_pop, bus.tx_send, bus.tx_data, bus.pkt_done);
    end
    reset_n = 1;
    last_tx = '0;
    n0 = cap.size();
    repeat (30) @(negedge clock);
    mon_en = 1;
    checks++;
    if (cap.size() != n0 || done_cnt != 1) begin
      errors++;
      $display("FAIL midreset_abort: %0d bytes and done=%0d after reset, required 0 and 1",
               cap.size() - n0, done_cnt);
    end
    cap.delete(); gq.delete(); exp_q.delete();
    for (int i = 0; i < NS; i++) begin didx[i] = 0; mexp[i] = 0; end
    done_cnt = 0;
    bus.req = 4'b0110;
    wait_grant(ok);
    checks++;
    if (bus.grant !== 4'b0010) begin
      errors++;
      $display("FAIL midreset_pointer: grant=%b, required 0010", bus.grant);
    end
    bus.req = '0;
    exp_pkt(1, 2);
    wait_done(1, ok);
    checks++;
    if (!same(cap, exp_q)) begin
      errors++;
      $display("FAIL midreset_bytes: got %s required %s", qs(cap), qs(exp_q));
    end
  endtask

  task automatic test_busy_pacing();
    bit ok;
    int n0;
    do_reset();
    busy_len = 5;
    for (int j = 0; j < 4; j++) pay[0][j] = 8'($urandom);
    bus.req_len[0 +: 8] = 8'd3;
    bus.req = 4'b0001;
    wait_grant(ok);
    bus.req = '0;
    force_busy = 1;
    n0 = cap.size();
    repeat (40) @(negedge clock);
    checks++;
    if (cap.size() != n0) begin
      errors++;
      $display("FAIL busy_hold: %0d bytes sent while busy held, required 0", cap.size() - n0);
    end
    force_busy = 0;
    exp_pkt(0, 3);
    wait_done(1, ok);
    checks++;
    if (!ok || !same(cap, exp_q)) begin
      errors++;
      $display("FAIL busy_bytes: got %s required %s", qs(cap), qs(exp_q));
    end
    checks++;
    if (viol != 0 || unstable != 0) begin
      errors++;
      $display("FAIL busy_handshake: send_while_busy=%0d data_changes=%0d, required 0 and 0", viol, unstable);
    end
  endtask

  task automatic test_random();
    bit ok;
    int p, w, m, win;
    int lens [NS];
    do_reset();
    for (int i = 0; i < NS; i++) for (int j = 0; j < 64; j++) pay[i][j] = 8'($urandom);
    p = 0;
    for (int r = 0; r < 8; r++) begin
      m = $urandom_range(1, 15);
      busy_len = $urandom_range(1, 8);
      for (int i = 0; i < NS; i++) begin
        lens[i] = $urandom_range(0, 6);
        bus.req_len[8*i +: 8] = 8'(lens[i]);
      end
      bus.req = 4'(m);
      wait_grant(ok);
      bus.req = '0;
      w = -1;
      for (int o = NS - 1; o >= 0; o--) if (m[(p + o) % NS]) w = (p + o) % NS;
      win = -1;
      for (int i = 0; i < NS; i++) if (bus.grant[i]) win = i;
      checks++;
      if (win != w) begin
        errors++;
        $display("FAIL rr_round%0d: granted %0d for req=%b ptr=%0d, required %0d", r, win, 4'(m), p, w);
      end
      exp_pkt(w, lens[w]);
      p = (w + 1) % NS;
      wait_done(r + 1, ok);
    end
    checks++;
    if (!same(cap, exp_q)) begin
      errors++;
      $display("FAIL random_bytes: got %s required %s", qs(cap), qs(exp_q));
    end
    checks++;
    if (viol != 0 || unstable != 0 || two_hot != 0) begin
      errors++;
      $display("FAIL random_protocol: send_while_busy=%0d data_changes=%0d twohot=%0d, required 0",
               viol, unstable, two_hot);
    end
  endtask

  initial begin
    bus.req = '0;
    bus.req_len = '0;
    for (int i = 0; i < NS; i++) for (int j = 0; j < 64; j++) pay[i][j] = '0;
    test_reset();
    test_single();
    test_zero_len();
    test_contention();
    test_grant_lock();
    test_reset_mid();
    test_busy_pacing();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
